// File: rtl/mips_ctrl_pkg.sv
//==============================================================================
// Module   : mips_ctrl_pkg
// Purpose  : Shared state encodings, opcode/funct constants, ALUOp and
//            ALUControl codes for the multi-cycle MIPS control unit and alu.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package mips_ctrl_pkg;

    typedef logic [3:0] state_t;

    localparam state_t c_st_fetch   = 4'd0;
    localparam state_t c_st_decode  = 4'd1;
    localparam state_t c_st_memadr  = 4'd2;
    localparam state_t c_st_memrd   = 4'd3;
    localparam state_t c_st_memwb   = 4'd4;
    localparam state_t c_st_memwr   = 4'd5;
    localparam state_t c_st_execute = 4'd6;
    localparam state_t c_st_aluwb   = 4'd7;
    localparam state_t c_st_branch  = 4'd8;
    localparam state_t c_st_addiex  = 4'd9;
    localparam state_t c_st_addiwb  = 4'd10;
    localparam state_t c_st_jump    = 4'd11;
    localparam state_t c_st_bne     = 4'd12;

    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_bne   = 6'b000101;
    localparam logic [5:0] c_op_addi  = 6'b001000;
    localparam logic [5:0] c_op_j     = 6'b000010;

    localparam logic [5:0] c_funct_add = 6'b100000;
    localparam logic [5:0] c_funct_sub = 6'b100010;
    localparam logic [5:0] c_funct_and = 6'b100100;
    localparam logic [5:0] c_funct_or  = 6'b100101;
    localparam logic [5:0] c_funct_slt = 6'b101010;

    localparam logic [1:0] c_aluop_add   = 2'b00;
    localparam logic [1:0] c_aluop_sub   = 2'b01;
    localparam logic [1:0] c_aluop_funct = 2'b10;

    localparam logic [2:0] c_aluctl_and = 3'b000;
    localparam logic [2:0] c_aluctl_or  = 3'b001;
    localparam logic [2:0] c_aluctl_add = 3'b010;
    localparam logic [2:0] c_aluctl_sub = 3'b110;
    localparam logic [2:0] c_aluctl_slt = 3'b111;

endpackage

`default_nettype wire

// File: rtl/mips_mc_control_if.sv
//==============================================================================
// Module   : mips_mc_control_if
// Purpose  : Control-to-datapath bundle: instruction fields and zero flag in,
//            mux selects, enables and ALUControl out.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface mips_mc_control_if #(
    parameter int OP_WIDTH         = 6,
    parameter int FUNCT_WIDTH      = 6,
    parameter int ALUControl_WIDTH = 3
);
    logic [OP_WIDTH-1:0]         Op;
    logic [FUNCT_WIDTH-1:0]      Funct;
    logic                        zero;
    logic                        IorD;
    logic                        MemWrite;
    logic                        IRWrite;
    logic                        RegDst;
    logic                        MemtoReg;
    logic                        RegWrite;
    logic                        ALUSrcA;
    logic [1:0]                  ALUSrcB;
    logic [1:0]                  PCSrc;
    logic                        PCEn;
    logic [ALUControl_WIDTH-1:0] ALUControl;
    logic [3:0]                  state_o;

    modport master (
        input  Op, Funct, zero,
        output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, PCSrc, PCEn, ALUControl, state_o
    );

    modport slave (
        output Op, Funct, zero,
        input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, PCSrc, PCEn, ALUControl, state_o
    );
endinterface

`default_nettype wire

// File: rtl/mips_alu_decoder.sv
//==============================================================================
// Module   : mips_alu_decoder
// Purpose  : Combinational ALUOp/Funct to ALUControl mapping.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module mips_alu_decoder
    import mips_ctrl_pkg::*;
#(
    parameter int FUNCT_WIDTH      = 6,
    parameter int ALUControl_WIDTH = 3
) (
    input  wire logic [1:0]                  i_alu_op,
    input  wire logic [FUNCT_WIDTH-1:0]      i_funct,
    output logic      [ALUControl_WIDTH-1:0] o_alu_control
);

    always_comb begin
        o_alu_control = c_aluctl_add;
        case (i_alu_op)
            c_aluop_sub:   o_alu_control = c_aluctl_sub;
            c_aluop_funct: begin
                // Unrecognised funct codes fall back to add.
                case (i_funct)
                    c_funct_sub: o_alu_control = c_aluctl_sub;
                    c_funct_and: o_alu_control = c_aluctl_and;
                    c_funct_or:  o_alu_control = c_aluctl_or;
                    c_funct_slt: o_alu_control = c_aluctl_slt;
                    default:     o_alu_control = c_aluctl_add;
                endcase
            end
            default:       o_alu_control = c_aluctl_add;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mips_mc_control.sv
//==============================================================================
// Module   : mips_mc_control
// Purpose  : Multi-cycle MIPS main Moore FSM plus ALU decoder.
//            Optional bne support via macro MIPS_CTRL_BNE_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module mips_mc_control
    import mips_ctrl_pkg::*;
#(
    parameter int OP_WIDTH         = 6,
    parameter int FUNCT_WIDTH      = 6,
    parameter int ALUControl_WIDTH = 3
) (
    input  wire logic           clk,
    input  wire logic           rst,
    mips_mc_control_if.master   bus
);

    state_t                r_state;
    state_t                w_state;
    state_t                w_next_state;
    logic [OP_WIDTH-1:0]   w_op;
    logic [1:0]            w_alu_op;
    logic                  w_pc_write;
    logic                  w_branch;
    logic                  w_branch_ne;
    logic                  w_iord;
    logic                  w_mem_write;
    logic                  w_ir_write;
    logic                  w_reg_dst;
    logic                  w_mem_to_reg;
    logic                  w_reg_write;
    logic                  w_alu_src_a;
    logic [1:0]            w_alu_src_b;
    logic [1:0]            w_pc_src;

    assign w_op = bus.Op;

    // While in reset the outputs present FETCH decoding, with enables masked below.
    assign w_state = rst ? c_st_fetch : r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_fetch;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = c_st_fetch;
        case (w_state)
            c_st_fetch:   w_next_state = c_st_decode;
            c_st_decode: begin
                case (w_op)
                    c_op_lw, c_op_sw: w_next_state = c_st_memadr;
                    c_op_rtype:       w_next_state = c_st_execute;
                    c_op_beq:         w_next_state = c_st_branch;
                    c_op_addi:        w_next_state = c_st_addiex;
                    c_op_j:           w_next_state = c_st_jump;
`ifdef MIPS_CTRL_BNE_EN
                    c_op_bne:         w_next_state = c_st_bne;
`endif
                    default:          w_next_state = c_st_fetch;
                endcase
            end
            c_st_memadr:  w_next_state = (w_op == c_op_sw) ? c_st_memwr : c_st_memrd;
            c_st_memrd:   w_next_state = c_st_memwb;
            c_st_execute: w_next_state = c_st_aluwb;
            c_st_addiex:  w_next_state = c_st_addiwb;
            default:      w_next_state = c_st_fetch;
        endcase
    end

    always_comb begin
        w_iord       = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_dst    = 1'b0;
        w_mem_to_reg = 1'b0;
        w_reg_write  = 1'b0;
        w_alu_src_a  = 1'b0;
        w_alu_src_b  = 2'b00;
        w_pc_src     = 2'b00;
        w_alu_op     = c_aluop_add;
        w_pc_write   = 1'b0;
        w_branch     = 1'b0;
        w_branch_ne  = 1'b0;
        case (w_state)
            c_st_fetch: begin
                w_alu_src_b = 2'b01;
                w_ir_write  = 1'b1;
                w_pc_write  = 1'b1;
            end
            c_st_decode:  w_alu_src_b = 2'b11;
            c_st_memadr, c_st_addiex: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
            end
            c_st_memrd:   w_iord = 1'b1;
            c_st_memwb: begin
                w_mem_to_reg = 1'b1;
                w_reg_write  = 1'b1;
            end
            c_st_memwr: begin
                w_iord      = 1'b1;
                w_mem_write = 1'b1;
            end
            c_st_execute: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = c_aluop_funct;
            end
            c_st_aluwb: begin
                w_reg_dst   = 1'b1;
                w_reg_write = 1'b1;
            end
            c_st_branch: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = c_aluop_sub;
                w_pc_src    = 2'b01;
                w_branch    = 1'b1;
            end
            c_st_addiwb:  w_reg_write = 1'b1;
            c_st_jump: begin
                w_pc_src   = 2'b10;
                w_pc_write = 1'b1;
            end
`ifdef MIPS_CTRL_BNE_EN
            c_st_bne: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = c_aluop_sub;
                w_pc_src    = 2'b01;
                w_branch_ne = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    mips_alu_decoder #(
        .FUNCT_WIDTH      (FUNCT_WIDTH),
        .ALUControl_WIDTH (ALUControl_WIDTH)
    ) u_alu_decoder (
        .i_alu_op      (w_alu_op),
        .i_funct       (bus.Funct),
        .o_alu_control (bus.ALUControl)
    );

    assign bus.IorD     = w_iord;
    assign bus.MemWrite = w_mem_write & ~rst;
    assign bus.IRWrite  = w_ir_write & ~rst;
    assign bus.RegDst   = w_reg_dst;
    assign bus.MemtoReg = w_mem_to_reg;
    assign bus.RegWrite = w_reg_write & ~rst;
    assign bus.ALUSrcA  = w_alu_src_a;
    assign bus.ALUSrcB  = w_alu_src_b;
    assign bus.PCSrc    = w_pc_src;
    assign bus.PCEn     = ~rst & (w_pc_write | (w_branch & bus.zero) | (w_branch_ne & ~bus.zero));
    assign bus.state_o  = w_state;

endmodule

`default_nettype wire

// File: tb/tb_mips_mc_control.sv
//==============================================================================
// Module   : tb_mips_mc_control
// Purpose  : Scoreboard bench for mips_mc_control (honours MIPS_CTRL_BNE_EN).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mips_mc_control;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mips_mc_control_if bus ();

    mips_mc_control dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       iord;
        logic       memw;
        logic       irw;
        logic       regdst;
        logic       m2r;
        logic       regw;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] pcsrc;
        logic       pcen;
        logic [2:0] aluc;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Expected outputs per state, written out from the state table.
    function automatic exp_t model(logic [3:0] st, logic [5:0] f, logic z, logic r);
        exp_t e;
        e      = '0;
        e.aluc = 3'b010;
        if (r) begin
            e.srcb = 2'b01;
            return e;
        end
        e.st = st;
        case (st)
            4'd0:  begin e.irw = 1'b1; e.srcb = 2'b01; e.pcen = 1'b1; end
            4'd1:  e.srcb = 2'b11;
            4'd2:  begin e.srca = 1'b1; e.srcb = 2'b10; end
            4'd3:  e.iord = 1'b1;
            4'd4:  begin e.m2r = 1'b1; e.regw = 1'b1; end
            4'd5:  begin e.iord = 1'b1; e.memw = 1'b1; end
            4'd6: begin
                e.srca = 1'b1;
                case (f)
                    6'b100010: e.aluc = 3'b110;
                    6'b100100: e.aluc = 3'b000;
                    6'b100101: e.aluc = 3'b001;
                    6'b101010: e.aluc = 3'b111;
                    default:   e.aluc = 3'b010;
                endcase
            end
            4'd7:  begin e.regdst = 1'b1; e.regw = 1'b1; end
            4'd8:  begin e.srca = 1'b1; e.pcsrc = 2'b01; e.aluc = 3'b110; e.pcen = z; end
            4'd9:  begin e.srca = 1'b1; e.srcb = 2'b10; end
            4'd10: e.regw = 1'b1;
            4'd11: begin e.pcsrc = 2'b10; e.pcen = 1'b1; end
            4'd12: begin e.srca = 1'b1; e.pcsrc = 2'b01; e.aluc = 3'b110; e.pcen = ~z; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [3:0] st);
        q.push_back(model(st, bus.Funct, bus.zero, rst));
        cyc();
    endtask

    task automatic instr(input logic [5:0] op, input logic [5:0] f, input logic z,
                         input logic [19:0] seq, input int n);
        bus.Op    = op;
        bus.Funct = f;
        bus.zero  = z;
        for (int i = 0; i < n; i++) begin
            step(seq[19-4*i -: 4]);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        exp_t a;
        if (q.size() != 0) begin
            e        = q.pop_front();
            a.st     = bus.state_o;
            a.iord   = bus.IorD;
            a.memw   = bus.MemWrite;
            a.irw    = bus.IRWrite;
            a.regdst = bus.RegDst;
            a.m2r    = bus.MemtoReg;
            a.regw   = bus.RegWrite;
            a.srca   = bus.ALUSrcA;
            a.srcb   = bus.ALUSrcB;
            a.pcsrc  = bus.PCSrc;
            a.pcen   = bus.PCEn;
            a.aluc   = bus.ALUControl;
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs@state%0d t=%0t: got %b required %b", e.st, $time, a, e);
            end
        end
    end

    initial begin
        bus.Op    = 6'b0;
        bus.Funct = 6'b0;
        bus.zero  = 1'b0;
        rst       = 1'b1;
        cyc();
        step(4'd0);
        step(4'd0);
        rst = 1'b0;

        instr(6'b100011, 6'b000000, 1'b0, {4'd0, 4'd1, 4'd2, 4'd3, 4'd4}, 5);  // lw
        instr(6'b000000, 6'b100010, 1'b0, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0}, 4);  // sub
        instr(6'b000000, 6'b101010, 1'b1, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0}, 4);  // slt
        instr(6'b000000, 6'b100000, 1'b0, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0}, 4);  // add
        instr(6'b000000, 6'b100100, 1'b0, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0}, 4);  // and
        instr(6'b000000, 6'b100101, 1'b0, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0}, 4);  // or
        instr(6'b000000, 6'b111001, 1'b0, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0}, 4);  // odd funct
        instr(6'b000100, 6'b100101, 1'b1, {4'd0, 4'd1, 4'd8, 8'd0}, 3);        // beq taken
        instr(6'b000100, 6'b100101, 1'b0, {4'd0, 4'd1, 4'd8, 8'd0}, 3);        // beq not taken
        instr(6'b101011, 6'b000000, 1'b0, {4'd0, 4'd1, 4'd2, 4'd5, 4'd0}, 4);  // sw
        instr(6'b000010, 6'b000000, 1'b0, {4'd0, 4'd1, 4'd11, 8'd0}, 3);       // j
        instr(6'b001000, 6'b101010, 1'b0, {4'd0, 4'd1, 4'd9, 4'd10, 4'd0}, 4); // addi
        instr(6'b111111, 6'b000000, 1'b1, {4'd0, 4'd1, 12'd0}, 2);             // unknown op
`ifdef MIPS_CTRL_BNE_EN
        instr(6'b000101, 6'b000000, 1'b0, {4'd0, 4'd1, 4'd12, 8'd0}, 3);
        instr(6'b000101, 6'b000000, 1'b1, {4'd0, 4'd1, 4'd12, 8'd0}, 3);
`else
        instr(6'b000101, 6'b000000, 1'b0, {4'd0, 4'd1, 12'd0}, 2);
        instr(6'b000101, 6'b000000, 1'b1, {4'd0, 4'd1, 12'd0}, 2);
`endif
        // lw aborted by reset while in MEMRD.
        instr(6'b100011, 6'b000000, 1'b0, {4'd0, 4'd1, 4'd2, 8'd0}, 3);
        rst = 1'b1;
        step(4'd0);
        rst = 1'b0;
        instr(6'b000010, 6'b000000, 1'b0, {4'd0, 4'd1, 4'd11, 8'd0}, 3);       // j after abort

        for (int i = 0; i < 4 && q.size() != 0; i++) begin
            cyc();
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d entries pending required 0", q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mips_mc_control.md
Name: mips_mc_control

Overview:
- Control unit for the multi-cycle MIPS datapath.
- Sits directly upstream of the alu: drives ALUControl, SrcA/SrcB mux selects and every datapath enable.
- Consumes the alu zero flag to form the PC enable.
- Main Moore FSM sequences each instruction over 3-5 cycles; a combinational ALU decoder maps ALUOp/Funct to the 3-bit ALUControl.

Parameters:
- OP_WIDTH, 6, opcode field width (Instr[31:26])
- FUNCT_WIDTH, 6, funct field width (Instr[5:0])
- ALUControl_WIDTH, 3, width of ALUControl; must match the alu parameter of the same name

Ports:
- clk  in  1  single clock; all state changes on posedge
- rst  in  1  synchronous, active-high reset
- Op  in  OP_WIDTH  opcode from the instruction register
- Funct  in  FUNCT_WIDTH  funct field from the instruction register
- zero  in  1  alu zero flag (combinational, current cycle)
- IorD  out  1  memory address select: 0=PC, 1=ALUOut
- MemWrite  out  1  data memory write enable
- IRWrite  out  1  instruction register load enable
- RegDst  out  1  write register select: 0=rt, 1=rd
- MemtoReg  out  1  writeback select: 0=ALUOut, 1=Data
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  0=PC, 1=A register
- ALUSrcB  out  2  00=B, 01=const 4, 10=SignImm, 11=SignImm<<2
- PCSrc  out  2  00=ALUResult, 01=ALUOut, 10=jump target
- PCEn  out  1  PC load enable = PCWrite | (Branch & zero)
- ALUControl  out  ALUControl_WIDTH  alu operation code
- state_o  out  4  current FSM state encoding, for the bench

Behaviour:
- ALUControl codes: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- ALUOp encoding: 00 add, 01 sub, 10 use Funct.
- Funct mapping: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111; any other Funct→010.
- Opcodes: lw 100011, sw 101011, R-type 000000, beq 000100, addi 001000, j 000010.

FSM states and encodings:
- FETCH 0: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00, IRWrite=1, PCWrite=1 → DECODE.
- DECODE 1: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by opcode:
  - lw/sw → MEMADR
  - R → EXECUTE
  - beq → BRANCH
  - addi → ADDIEX
  - j → JUMP
  - any other opcode → FETCH (treated as NOP; no write enable asserted)
- MEMADR 2: ALUSrcA=1, ALUSrcB=10, ALUOp=00 → MEMRD if lw, MEMWR if sw.
- MEMRD 3: IorD=1 → MEMWB.
- MEMWB 4: RegDst=0, MemtoReg=1, RegWrite=1 → FETCH.
- MEMWR 5: IorD=1, MemWrite=1 → FETCH.
- EXECUTE 6: ALUSrcA=1, ALUSrcB=00, ALUOp=10 → ALUWB.
- ALUWB 7: RegDst=1, MemtoReg=0, RegWrite=1 → FETCH.
- BRANCH 8: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1 → FETCH.
- ADDIEX 9: ALUSrcA=1, ALUSrcB=10, ALUOp=00 → ADDIWB.
- ADDIWB 10: RegDst=0, MemtoReg=0, RegWrite=1 → FETCH.
- JUMP 11: PCSrc=10, PCWrite=1 → FETCH.

Unlisted outputs and output timing:
- Signals not listed for a state are 0; mux selects not listed are 00/0.
- ALUControl and PCEn are combinational from state, Funct and zero.
- All other outputs decode from the state register only.

Latency, counted from the FETCH cycle inclusive:
- lw 5 cycles
- sw, R-type, addi 4 cycles
- beq, j 3 cycles
- unknown opcode 2 cycles

Reset:
- rst sampled at posedge loads FETCH.
- While rst=1, MemWrite, IRWrite, RegWrite and PCEn are forced 0. Muxes and ALUControl show FETCH values (IorD=0, ALUSrcB=01, ALUControl=010); state_o=0.
- rst asserted mid-instruction aborts it at the next edge; no partial write is issued in the reset cycle.
- Encodings 12-15 are unreachable; if entered, next state is FETCH with all enables 0.

Optional Feature:
- Macro MIPS_CTRL_BNE_EN.
- When defined: opcode 000101 (bne) in DECODE → state BNE 12. BNE has the same outputs as BRANCH, but PCEn = ~zero instead of zero; next state FETCH.
- When undefined: 000101 is an unknown opcode → FETCH, and encoding 12 is unreachable.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state enum and encodings
  - opcode constants
  - funct constants
  - ALUOp codes
  - ALUControl codes (shared with the alu and its bench)
- One sub-module: mips_alu_decoder (ALUOp, Funct → ALUControl), purely combinational, instantiated once.

Test Plan:
- Reset, then lw (Op=100011): state_o sequence 0,1,2,3,4,0. IRWrite=1 only in state 0; RegWrite=1 with MemtoReg=1 only in state 4; ALUControl=010 in state 2.
- R-type sub (Op=0, Funct=100010): ALUControl=110 in state 6. State 7 has RegDst=1, RegWrite=1. Repeat for slt (101010): ALUControl=111.
- beq: with zero=1 in state 8, PCEn=1 and PCSrc=01. With zero=0, PCEn=0. ALUControl=010 in state 8 is wrong; must be 110.
- sw then j: sw gives MemWrite=1 for exactly 1 cycle in state 5, IorD=1. j gives PCEn=1, PCSrc=10 in state 11, 3-cycle total.
- Op=111111 → FETCH after DECODE with no enable asserted. rst raised in state 3 → state_o=0 next edge, RegWrite never 1.
- With MIPS_CTRL_BNE_EN: Op=000101, zero=0 → PCEn=1 in state 12. zero=1 → PCEn=0. Without the macro, the same Op returns to FETCH.
